// File: rtl/reg_wb_sched.sv
// Writeback scheduler: round-robin arbiter (ALU/LD/INC) onto the single reg_file write port,
// plus a pending-write scoreboard for RAW hazard detection. Optional forwarding: WB_BYPASS_EN.
module reg_wb_sched #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CG_REG = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_da,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_da,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              inc_valid,
    output logic              inc_ready,
    input  logic [ADDR_W-1:0] inc_da,
    input  logic [DATA_W-1:0] inc_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_da,
    input  logic [ADDR_W-1:0] SA,
    output logic              hazard,
    output logic              RW,
    output logic [ADDR_W-1:0] DA,
    output logic [DATA_W-1:0] Din,
`ifdef WB_BYPASS_EN
    output logic              bypass_valid,
    output logic [DATA_W-1:0] bypass_data,
`endif
    output logic              busy
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CG_DA = ADDR_W'(CG_REG);

    logic [1:0]        rr_ptr;
    logic [1:0]        rr_next;
    logic [2:0]        req;
    logic [2:0]        gnt;
    logic [ADDR_W-1:0] sel_da;
    logic [DATA_W-1:0] sel_data;
    logic              acc;
    logic              acc_cg;
    logic              cg_clr;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;

    assign req = {inc_valid, ld_valid, alu_valid};

    // Search order starts at rr_ptr and wraps modulo 3.
    always_comb begin
        gnt = 3'b000;
        case (rr_ptr)
            2'd1:    gnt = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
            2'd2:    gnt = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
            default: gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        endcase
    end

    always_comb begin
        sel_da   = alu_da;
        sel_data = alu_data;
        rr_next  = rr_ptr;
        if (gnt[0]) begin
            rr_next = 2'd1;
        end else if (gnt[1]) begin
            sel_da   = ld_da;
            sel_data = ld_data;
            rr_next  = 2'd2;
        end else if (gnt[2]) begin
            sel_da   = inc_da;
            sel_data = inc_data;
            rr_next  = 2'd0;
        end
    end

    assign alu_ready = gnt[0];
    assign ld_ready  = gnt[1];
    assign inc_ready = gnt[2];
    assign acc       = |gnt;
    assign acc_cg    = acc && (sel_da == CG_DA);

    // Set is applied last so a fresh reservation beats a same-cycle retirement.
    always_comb begin
        pending_nxt = pending;
        if (RW)
            pending_nxt[DA] = 1'b0;
        if (cg_clr)
            pending_nxt[CG_REG] = 1'b0;
        if (issue_valid)
            pending_nxt[issue_da] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= 2'd0;
            RW      <= 1'b0;
            DA      <= '0;
            Din     <= '0;
            cg_clr  <= 1'b0;
            pending <= '0;
        end else begin
            RW      <= acc && !acc_cg;
            cg_clr  <= acc_cg;
            pending <= pending_nxt;
            rr_ptr  <= rr_next;
            if (acc && !acc_cg) begin
                DA  <= sel_da;
                Din <= sel_data;
            end
        end
    end

    assign busy = |pending;

`ifdef WB_BYPASS_EN
    assign bypass_valid = RW && (DA == SA) && (DA != CG_DA);
    assign bypass_data  = Din;
    assign hazard       = pending[SA] && !bypass_valid;
`else
    assign hazard       = pending[SA];
`endif

endmodule

// File: tb/tb_reg_wb_sched.sv
// Self-checking bench for reg_wb_sched: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_reg_wb_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p_valid [3];
    logic [3:0]  p_da    [3];
    logic [15:0] p_data  [3];
    logic        alu_ready, ld_ready, inc_ready;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_da = '0;
    logic [3:0]  SA = '0;
    logic        hazard, RW, busy;
    logic [3:0]  DA;
    logic [15:0] Din;
`ifdef WB_BYPASS_EN
    logic        bypass_valid;
    logic [15:0] bypass_data;
`endif

    int errors = 0;
    int checks = 0;

    // reference model state
    bit [15:0] m_pend = '0;
    int        m_rr = 0;
    bit        m_rw = 0;
    bit        m_cg = 0;
    bit [3:0]  m_da = '0;
    bit [15:0] m_din = '0;
    bit        acc [3];

    always #5 clk = ~clk;

    reg_wb_sched dut (
        .clk(clk), .rst(rst),
        .alu_valid(p_valid[0]), .alu_ready(alu_ready), .alu_da(p_da[0]), .alu_data(p_data[0]),
        .ld_valid(p_valid[1]),  .ld_ready(ld_ready),   .ld_da(p_da[1]),  .ld_data(p_data[1]),
        .inc_valid(p_valid[2]), .inc_ready(inc_ready), .inc_da(p_da[2]), .inc_data(p_data[2]),
        .issue_valid(issue_valid), .issue_da(issue_da), .SA(SA),
        .hazard(hazard), .RW(RW), .DA(DA), .Din(Din),
`ifdef WB_BYPASS_EN
        .bypass_valid(bypass_valid), .bypass_data(bypass_data),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            p_valid[i] = 1'b0;
            p_da[i]    = '0;
            p_data[i]  = '0;
            acc[i]     = 0;
        end
        issue_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_pend = '0; m_rr = 0; m_rw = 0; m_cg = 0; m_da = '0; m_din = '0;
    endtask

    // Advance to the falling edge and retire producers accepted in the previous cycle.
    task automatic next_edge();
        @(negedge clk);
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) p_valid[i] = 1'b0;
            acc[i] = 0;
        end
    endtask

    // Check all outputs for this cycle, then advance the model across the coming rising edge.
    task automatic cyc();
        int g;
        bit exp_hz;
        bit [15:0] nxt;
        #1;
        g = -1;
        for (int k = 0; k < 3; k++)
            if (g < 0 && p_valid[(m_rr + k) % 3]) g = (m_rr + k) % 3;
        chk("alu_ready", alu_ready, g == 0);
        chk("ld_ready",  ld_ready,  g == 1);
        chk("inc_ready", inc_ready, g == 2);
        chk("RW",  RW,  m_rw);
        chk("DA",  DA,  m_da);
        chk("Din", Din, m_din);
        chk("busy", busy, m_pend != 0);
        exp_hz = m_pend[SA];
`ifdef WB_BYPASS_EN
        chk("bypass_valid", bypass_valid, m_rw && m_da == SA);
        chk("bypass_data",  bypass_data,  m_din);
        if (m_rw && m_da == SA) exp_hz = 0;
`endif
        chk("hazard", hazard, exp_hz);

        nxt = m_pend;
        if (m_rw) nxt[m_da] = 0;
        if (m_cg) nxt[3] = 0;
        if (issue_valid) nxt[issue_da] = 1;
        m_pend = nxt;
        m_rw = 0;
        m_cg = 0;
        if (g >= 0) begin
            acc[g] = 1;
            if (p_da[g] == 4'd3) begin
                m_cg = 1;
            end else begin
                m_rw  = 1;
                m_da  = p_da[g];
                m_din = p_data[g];
            end
            m_rr = (g + 1) % 3;
        end
    endtask

    task automatic req(input int i, input logic [3:0] da, input logic [15:0] data);
        p_valid[i] = 1'b1;
        p_da[i]    = da;
        p_data[i]  = data;
    endtask

    task automatic reserve(input logic [3:0] da);
        next_edge();
        issue_valid = 1'b1;
        issue_da    = da;
        cyc();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // reset state
        next_edge();
        cyc();

        // all three producers at once
        next_edge();
        req(0, 4'd4, 16'h1111);
        req(1, 4'd5, 16'h2222);
        req(2, 4'd6, 16'h3333);
        cyc();
        repeat (4) begin
            next_edge();
            cyc();
        end
        chk("t2_last_din", Din, 16'h3333);

        // reservation then ALU retirement of R7
        SA = 4'd7;
        reserve(4'd7);
        repeat (3) begin next_edge(); cyc(); end
        next_edge();
        req(0, 4'd7, 16'hBEEF);
        cyc();
        next_edge();
        cyc();
        chk("t3_din", Din, 16'hBEEF);
        next_edge();
        cyc();
        chk("t3_hazard_clear", hazard, 1'b0);

        // re-reserve R9 in the cycle it retires
        SA = 4'd9;
        reserve(4'd9);
        next_edge();
        req(1, 4'd9, 16'h0909);
        cyc();
        next_edge();
        issue_valid = 1'b1;
        issue_da    = 4'd9;
        cyc();
        next_edge();
        cyc();
        chk("t4_r9_hazard", hazard, 1'b1);

        // constant-generator destination is dropped
        SA = 4'd3;
        reserve(4'd3);
        next_edge();
        req(2, 4'd3, 16'hFFFF);
        cyc();
        next_edge();
        cyc();
        chk("t5_rw", RW, 1'b0);
        next_edge();
        cyc();
        chk("t5_pend3", hazard, 1'b0);

        // forwarding window on R5
        SA = 4'd5;
        reserve(4'd5);
        next_edge();
        req(0, 4'd5, 16'hA5A5);
        cyc();
        next_edge();
        cyc();
`ifdef WB_BYPASS_EN
        chk("t6_hazard", hazard, 1'b0);
`else
        chk("t6_hazard", hazard, 1'b1);
`endif

        // asynchronous reset in the middle of a write
        reserve(4'd4);
        reserve(4'd5);
        next_edge();
        req(0, 4'd4, 16'h4444);
        cyc();
        next_edge();
        #1;
        chk("t1_pre_rw", RW, 1'b1);
        chk("t1_pre_busy", busy, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk("t1_rw", RW, 1'b0);
        chk("t1_busy", busy, 1'b0);
        chk("t1_da", DA, 4'd0);
        chk("t1_din", Din, 16'd0);
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // randomized traffic
        repeat (400) begin
            next_edge();
            for (int i = 0; i < 3; i++)
                if (!p_valid[i] && ($urandom % 2 == 1))
                    req(i, 4'($urandom_range(0, 15)), 16'($urandom));
            issue_valid = ($urandom % 3 == 0);
            issue_da    = 4'($urandom_range(0, 15));
            SA          = ($urandom % 2 == 1) ? m_da : 4'($urandom_range(0, 15));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
